// File: rtl/reqrsp_rsp_sink_if.sv
// reqrsp_rsp_sink_if: valid/ready/data response channel between an upstream
// producer (master) and the response sink (slave).
interface reqrsp_rsp_sink_if #(
  parameter int unsigned WIDTH = 32
);
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output rsp_valid,
    output rsp_data,
    input  rsp_ready
  );

  modport slave (
    input  rsp_valid,
    input  rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/reqrsp_rsp_sink.sv
// reqrsp_rsp_sink: checks a response stream against base + i*step and reports
// beat/error counts and pass/fail/timeout. Optional REQRSP_RSP_SINK_THROTTLE_EN adds LFSR backpressure.
module reqrsp_rsp_sink #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  exp_base,
  input  logic [WIDTH-1:0]  exp_step,
  input  logic [15:0]       num_beats,
  reqrsp_rsp_sink_if.slave  rsp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       beat_count,
  output logic [15:0]       err_count,
  output logic [15:0]       first_err_idx,
  output logic [WIDTH-1:0]  first_err_data
);

  localparam int unsigned IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  // Reject configurations that would make the idle counter or LFSR degenerate.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("reqrsp_rsp_sink: TIMEOUT must be at least 2");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("reqrsp_rsp_sink: LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  exp_val;
  logic [WIDTH-1:0]  step_val;
  logic [15:0]       total_beats;
  logic [IDLE_W-1:0] idle_cnt;
  logic              handshake;
  logic              mismatch;

  assign handshake = rsp.rsp_valid && rsp.rsp_ready;
  assign mismatch  = (rsp.rsp_data != exp_val);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 16'h0000) && !timeout;

  // Run control and scoreboard: a start outside RUN snapshots the expected
  // sequence and clears all results; each accepted beat is compared and the
  // expected value advances by the latched step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      exp_val        <= '0;
      step_val       <= '0;
      total_beats    <= '0;
      idle_cnt       <= '0;
      timeout        <= 1'b0;
      beat_count     <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            exp_val        <= exp_base;
            step_val       <= exp_step;
            total_beats    <= num_beats;
            idle_cnt       <= '0;
            timeout        <= 1'b0;
            beat_count     <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            state          <= (num_beats == 16'h0000) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (handshake) begin
            if (mismatch) begin
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
              end
              if (err_count == 16'h0000) begin
                first_err_idx  <= beat_count;
                first_err_data <= rsp.rsp_data;
              end
            end
            exp_val    <= exp_val + step_val;
            beat_count <= beat_count + 16'd1;
            idle_cnt   <= '0;
            if (beat_count == total_beats - 16'd1) begin
              state <= S_DONE;
            end
          end else if (idle_cnt == IDLE_MAX) begin
            // Upstream went silent for TIMEOUT consecutive cycles.
            timeout <= 1'b1;
            state   <= S_DONE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REQRSP_RSP_SINK_THROTTLE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right; bit 0 gates ready.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (state != S_RUN) begin
      if (start) begin
        lfsr <= LFSR_SEED;
      end
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  assign rsp.rsp_ready = (state == S_RUN) && lfsr[0];
`else
  assign rsp.rsp_ready = (state == S_RUN);
`endif

endmodule

// File: tb/tb_reqrsp_rsp_sink.sv
// tb_reqrsp_rsp_sink: randomized self-checking bench for reqrsp_rsp_sink against a
// queue-based reference model of accepted beats.
module tb_reqrsp_rsp_sink;

  localparam int unsigned TIMEOUT    = 16;
  localparam int          MAX_CYCLES = 5000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] exp_base;
  logic [31:0] exp_step;
  logic [15:0] num_beats;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] beat_count;
  logic [15:0] err_count;
  logic [15:0] first_err_idx;
  logic [31:0] first_err_data;

  int checks = 0;
  int errors = 0;

  reqrsp_rsp_sink_if #(.WIDTH(32)) rsp_if ();

  reqrsp_rsp_sink #(
    .WIDTH(32),
    .TIMEOUT(TIMEOUT),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .exp_base(exp_base),
    .exp_step(exp_step),
    .num_beats(num_beats),
    .rsp(rsp_if.slave),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .beat_count(beat_count),
    .err_count(err_count),
    .first_err_idx(first_err_idx),
    .first_err_data(first_err_data)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: what the sink has accepted, as a plain list of beats.
  logic        m_run = 1'b0;
  logic        m_done = 1'b0;
  logic        m_to = 1'b0;
  int          m_idle = 0;
  int          m_num = 0;
  logic [31:0] m_base = '0;
  logic [31:0] m_step = '0;
  logic [31:0] m_beats[$];

  always @(negedge clock) begin
    logic [15:0] e_err;
    logic [15:0] e_fidx;
    logic [31:0] e_fdata;
    logic [31:0] e_exp;
    if (reset) begin
      m_run = 1'b0; m_done = 1'b0; m_to = 1'b0; m_idle = 0;
      m_beats.delete();
    end
    e_err = '0; e_fidx = '0; e_fdata = '0;
    for (int i = 0; i < m_beats.size(); i++) begin
      e_exp = m_base + 32'(i) * m_step;
      if (m_beats[i] != e_exp) begin
        if (e_err == 16'h0000) begin
          e_fidx  = 16'(i);
          e_fdata = m_beats[i];
        end
        if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
      end
    end
    checkOutput("busy", 32'(busy), 32'(m_run));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("timeout", 32'(timeout), 32'(m_to));
    checkOutput("pass", 32'(pass), 32'(m_done && e_err == 16'h0000 && !m_to));
    checkOutput("beat_count", 32'(beat_count), 32'(m_beats.size()));
    checkOutput("err_count", 32'(err_count), 32'(e_err));
    checkOutput("first_err_idx", 32'(first_err_idx), 32'(e_fidx));
    checkOutput("first_err_data", first_err_data, e_fdata);
`ifdef REQRSP_RSP_SINK_THROTTLE_EN
    if (!m_run) checkOutput("rsp_ready", 32'(rsp_if.rsp_ready), 32'h0);
`else
    checkOutput("rsp_ready", 32'(rsp_if.rsp_ready), 32'(m_run));
`endif
    if (!reset) begin
      if (m_run) begin
        if (rsp_if.rsp_valid && rsp_if.rsp_ready) begin
          m_beats.push_back(rsp_if.rsp_data);
          m_idle = 0;
          if (m_beats.size() == m_num) begin
            m_run = 1'b0; m_done = 1'b1;
          end
        end else begin
          m_idle++;
          if (m_idle >= int'(TIMEOUT)) begin
            m_run = 1'b0; m_done = 1'b1; m_to = 1'b1;
          end
        end
      end else if (start) begin
        m_base = exp_base; m_step = exp_step; m_num = int'(num_beats);
        m_beats.delete();
        m_to = 1'b0; m_idle = 0;
        if (num_beats == 16'h0000) begin
          m_run = 1'b0; m_done = 1'b1;
        end else begin
          m_run = 1'b1; m_done = 1'b0;
        end
      end
    end
  end

  // Launch one run and act as the upstream producer. Beats from bad_idx on,
  // every bad_stride-th, carry bad_val. abort_after>=0 resets mid-run.
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] step, input logic [15:0] n,
                               input int bad_idx, input int bad_stride, input logic [31:0] bad_val,
                               input int gap_pct, input int abort_after, input bit spurious,
                               output int cycles);
    int idx;
    bit hs;
    rsp_if.rsp_valid = 1'b1;
    rsp_if.rsp_data  = $urandom;
    @(posedge clock); #1;
    exp_base = base; exp_step = step; num_beats = n; start = 1'b1;
    rsp_if.rsp_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    idx = 0;
    cycles = 0;
    while (done !== 1'b1 && cycles < MAX_CYCLES) begin
      if (!rsp_if.rsp_valid && idx < int'(n) && int'($urandom_range(99)) >= gap_pct) begin
        rsp_if.rsp_valid = 1'b1;
        if (idx >= bad_idx && ((idx - bad_idx) % bad_stride) == 0)
          rsp_if.rsp_data = bad_val;
        else
          rsp_if.rsp_data = base + 32'(idx) * step;
      end
      if (spurious && $urandom_range(15) == 0) begin
        start = 1'b1; exp_base = $urandom; exp_step = $urandom; num_beats = 16'($urandom_range(3));
      end
      @(negedge clock);
      hs = rsp_if.rsp_valid && rsp_if.rsp_ready;
      @(posedge clock); #1;
      start = 1'b0;
      cycles++;
      if (hs) begin
        idx++;
        rsp_if.rsp_valid = 1'b0;
      end
      if (abort_after >= 0 && idx == abort_after) begin
        checkOutput("pre_reset_beats", 32'(beat_count), 32'(abort_after));
        reset = 1'b1;
        rsp_if.rsp_valid = 1'b0;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 32'h0);
        checkOutput("async_rst_beats", 32'(beat_count), 32'h0);
        checkOutput("async_rst_ready", 32'(rsp_if.rsp_ready), 32'h0);
        checkOutput("async_rst_done", 32'(done), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        return;
      end
    end
    rsp_if.rsp_valid = 1'b0;
    checkOutput("run_done", 32'(done), 32'h1);
  endtask

  initial begin
    int cyc;
    int n;
    reset = 1'b0; start = 1'b0; exp_base = '0; exp_step = '0; num_beats = '0;
    rsp_if.rsp_valid = 1'b0; rsp_if.rsp_data = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_ready", 32'(rsp_if.rsp_ready), 32'h0);
    checkOutput("reset_beats", 32'(beat_count), 32'h0);
    reset = 1'b0;

    applyStimulus(32'h10, 32'h1, 16'd4, -1, 1000, 32'h0, 0, -1, 1'b0, cyc);
    checkOutput("t1_beats", 32'(beat_count), 32'd4);
    checkOutput("t1_errs", 32'(err_count), 32'd0);
    checkOutput("t1_pass", 32'(pass), 32'h1);
`ifdef REQRSP_RSP_SINK_THROTTLE_EN
    checkOutput("t1_cycles_min", 32'(cyc >= 4), 32'h1);
`else
    checkOutput("t1_cycles", 32'(cyc), 32'd4);
`endif

    applyStimulus(32'h10, 32'h1, 16'd4, 2, 1000, 32'hDEAD, 0, -1, 1'b0, cyc);
    checkOutput("t2_errs", 32'(err_count), 32'd1);
    checkOutput("t2_fidx", 32'(first_err_idx), 32'd2);
    checkOutput("t2_fdata", first_err_data, 32'hDEAD);
    checkOutput("t2_pass", 32'(pass), 32'h0);

    applyStimulus(32'hFFFF_FFFE, 32'h1, 16'd3, -1, 1000, 32'h0, 0, -1, 1'b0, cyc);
    checkOutput("t3_wrap_pass", 32'(pass), 32'h1);
    checkOutput("t3_wrap_beats", 32'(beat_count), 32'd3);

    applyStimulus(32'h5, 32'h3, 16'd0, -1, 1000, 32'h0, 0, -1, 1'b0, cyc);
    checkOutput("t4_zero_done", 32'(done), 32'h1);
    checkOutput("t4_zero_pass", 32'(pass), 32'h1);
    checkOutput("t4_zero_cycles", 32'(cyc), 32'd0);

    applyStimulus(32'h7, 32'h1, 16'd5, -1, 1000, 32'h0, 100, -1, 1'b0, cyc);
    checkOutput("t5_to_cycles", 32'(cyc), 32'(TIMEOUT));
    checkOutput("t5_to_flag", 32'(timeout), 32'h1);
    checkOutput("t5_to_pass", 32'(pass), 32'h0);

    applyStimulus(32'h100, 32'h4, 16'd8, -1, 1000, 32'h0, 0, 2, 1'b0, cyc);
    applyStimulus(32'h200, 32'h4, 16'd8, -1, 1000, 32'h0, 0, -1, 1'b0, cyc);
    checkOutput("t6_clean_beats", 32'(beat_count), 32'd8);
    checkOutput("t6_clean_pass", 32'(pass), 32'h1);

`ifdef REQRSP_RSP_SINK_THROTTLE_EN
    applyStimulus(32'h1000, 32'h1, 16'd100, -1, 1000, 32'h0, 0, -1, 1'b0, cyc);
    checkOutput("thr_slow", 32'(cyc > 100), 32'h1);
    checkOutput("thr_beats", 32'(beat_count), 32'd100);
    checkOutput("thr_pass", 32'(pass), 32'h1);
`endif

    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(1, 40));
      applyStimulus($urandom, $urandom, 16'(n),
                    ($urandom_range(2) == 0) ? n + 1 : int'($urandom_range(0, n - 1)),
                    int'($urandom_range(1, 5)), $urandom,
                    int'($urandom_range(0, 40)), -1, 1'b1, cyc);
    end

    repeat (3) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reqrsp_rsp_sink.md
# reqrsp_rsp_sink

Downstream consumer for the response channel of the request/response loopback path. Accepts a valid/ready/data response stream, checks every beat against an arithmetic expected sequence, counts beats and mismatches, and reports pass/fail/timeout to the testbench. It can optionally apply pseudo-random backpressure to exercise the upstream FIFO's full/stall behaviour.

## Interface
- WIDTH, 32, response data width.
- TIMEOUT, 1024, max consecutive RUN cycles without a handshake before abort (≥2).
- LFSR_SEED, 16'hACE1, throttle LFSR seed (nonzero); used only with throttle compiled in.

- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a check run.
- exp_base  in  WIDTH  expected data of beat 0, sampled on start.
- exp_step  in  WIDTH  increment between expected beats, sampled on start.
- num_beats  in  16  beats in the run, sampled on start.
- rsp_valid  in  1  upstream response valid.
- rsp_ready  out  1  sink ready.
- rsp_data  in  WIDTH  response data.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done: err_count==0 and no timeout.
- timeout  out  1  run aborted by timeout.
- beat_count  out  16  handshakes accepted this run.
- err_count  out  16  mismatching beats this run, saturating at 16'hFFFF.
- first_err_idx  out  16  beat index of first mismatch.
- first_err_data  out  WIDTH  data of first mismatch.

## Operation
- States: IDLE → RUN → DONE; DONE → RUN on start.
- IDLE/DONE + start: latch exp_base into exp, exp_step, num_beats; clear beat_count, err_count, first_err_*, timeout, idle counter; load LFSR_SEED. Next state RUN, or DONE directly if num_beats==0 (pass=1).
- start while RUN: ignored.
- Handshake = rsp_valid && rsp_ready at posedge. On handshake: compare rsp_data to exp; mismatch → err_count+1 (saturating); if err_count was 0, capture first_err_idx=beat_count, first_err_data=rsp_data. Then exp <= exp + exp_step (mod 2^WIDTH), beat_count+1.
- Handshake on beat num_beats-1 → DONE next cycle.
- Idle counter: increments each RUN cycle without handshake, clears on handshake; reaching TIMEOUT-1 without handshake → timeout=1, DONE.
- Data offered while not in RUN is not accepted (rsp_ready=0); upstream holds it.
- pass = done && err_count==0 && !timeout; pass=0 outside DONE.

## Timing
- Reset values: rsp_ready=0, busy=0, done=0, pass=0, timeout=0, beat_count=0, err_count=0, first_err_idx=0, first_err_data=0; state IDLE.
- start at cycle N → busy=1 at N+1; rsp_ready can be high from N+1.
- rsp_ready is a registered-state function: RUN && throttle bit; not combinationally dependent on rsp_valid.
- Last handshake at cycle M → busy=0, done=1, pass valid at M+1; rsp_ready=0 at M+1 (no extra beat accepted).
- Full throughput: one beat per cycle when throttle absent.
- Counters/outputs update one cycle after the handshake edge; first_err_* hold until next start.
- Asynchronous reset mid-run: all outputs to reset values immediately; run discarded.

## Configuration
- REQRSP_RSP_SINK_THROTTLE_EN defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), loaded with LFSR_SEED on start, advances every RUN cycle; rsp_ready = RUN && lfsr[0].
- Undefined: no LFSR; rsp_ready = RUN (always ready during a run); LFSR_SEED unused.

## Test plan
- Reset, start with exp_base=32'h10, exp_step=1, num_beats=4, feed 10,11,12,13 back-to-back -> done 4 cycles after first handshake+1, beat_count=4, err_count=0, pass=1.
- Same run with beat 2 = 32'hDEAD -> err_count=1, first_err_idx=2, first_err_data=32'hDEAD, pass=0; beats 3 still checked against 13.
- exp_base=32'hFFFF_FFFE, exp_step=1, num_beats=3, feed FFFFFFFE, FFFFFFFF, 0 -> pass=1 (wrap).
- num_beats=0 start -> done=1, pass=1 next cycle, rsp_ready never asserted; TIMEOUT=16 with rsp_valid held low -> timeout=1, pass=0 after 16 RUN cycles.
- Reset asserted mid-run after 2 of 8 beats -> all outputs 0 immediately; new start runs cleanly with beat_count from 0.
- With REQRSP_RSP_SINK_THROTTLE_EN, rsp_valid always high, num_beats=100 -> rsp_ready toggles, data never lost/duplicated, pass=1, cycle count >100.
